// File: rtl/alu_seq_if.sv
// alu_seq_if: bundle between the instruction sequencer and the datapath.
// master = sequencer side (drives controls), slave = datapath side.
interface alu_seq_if #(
    parameter int unsigned NUM_REGS = 16
);
    logic                Start;
    logic [31:0]         IR_data;
    logic [NUM_REGS-1:0] Rin;
    logic [NUM_REGS-1:0] Rout;
    logic                PCout;
    logic                ZLOout;
    logic                ZHIout;
    logic                MDRout;
    logic                MARin;
    logic                Zin;
    logic                PCin;
    logic                MDRin;
    logic                IRin;
    logic                Yin;
    logic                LOin;
    logic                HIin;
    logic                IncrementPC;
    logic                Read;
    logic [4:0]          ALUControl;
    logic                Busy;
    logic                Done;
    logic                Error;

    modport master (
        input  Start, IR_data,
        output Rin, Rout, PCout, ZLOout, ZHIout, MDRout,
        output MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin,
        output IncrementPC, Read, ALUControl, Busy, Done, Error
    );

    modport slave (
        output Start, IR_data,
        input  Rin, Rout, PCout, ZLOout, ZHIout, MDRout,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin,
        input  IncrementPC, Read, ALUControl, Busy, Done, Error
    );
endinterface

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: fetch / decode / execute control-step sequencer for
// the register-register ALU datapath. Every control output is registered
// from the current step, so each step's controls appear one cycle after the
// state is entered. Optional feature macro: ALU_SEQ_ILLEGAL_TRAP_EN
// (illegal opcode / register index aborts after fetch and raises Error).
module alu_instr_sequencer #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned SEL_W    = 4,
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic      Clock,
    input  logic      Reset_n,
    alu_seq_if.master bus
);
    localparam int unsigned WAIT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT - 1);
    localparam logic [4:0] OP_PASS = 5'b00000;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_t;

    typedef struct packed {
        logic [NUM_REGS-1:0] rin;
        logic [NUM_REGS-1:0] rout;
        logic                pc_out;
        logic                zlo_out;
        logic                zhi_out;
        logic                mdr_out;
        logic                mar_in;
        logic                z_in;
        logic                pc_in;
        logic                mdr_in;
        logic                ir_in;
        logic                y_in;
        logic                lo_in;
        logic                hi_in;
        logic                inc_pc;
        logic                read;
        logic [4:0]          alu_ctrl;
        logic                busy;
        logic                done;
    } ctrl_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic              error_q, error_d;
    logic              trap_c;
    logic              unused_ir;

    logic [4:0]        opcode;
    logic [SEL_W-1:0]  ra, rb, rc;

    assign opcode    = bus.IR_data[31:27];
    assign ra        = bus.IR_data[26 -: SEL_W];
    assign rb        = bus.IR_data[22 -: SEL_W];
    assign rc        = bus.IR_data[18 -: SEL_W];
    assign unused_ir = ^bus.IR_data;

    // One-hot register select; an index past NUM_REGS selects nothing.
    function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            oh[i] = (32'(sel) == i);
        end
        return oh;
    endfunction

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    function automatic logic idx_bad(input logic [SEL_W-1:0] sel);
        return (32'(sel) >= NUM_REGS);
    endfunction

    // Legal ALU opcodes are 00011..10000 and all three register fields in range.
    assign trap_c = (opcode < 5'b00011) || (opcode > OP_DIV) ||
                    idx_bad(ra) || idx_bad(rb) || idx_bad(rc);
`else
    assign trap_c = 1'b0;
`endif

    // Next step, wait counter, error flag and the controls for the current step.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        error_d = error_q;
        ctrl_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    state_d = S_T0;
                    error_d = 1'b0;
                end
            end
            S_T0: begin
                ctrl_d.pc_out   = 1'b1;
                ctrl_d.mar_in   = 1'b1;
                ctrl_d.z_in     = 1'b1;
                ctrl_d.alu_ctrl = OP_PASS;
                ctrl_d.busy     = 1'b1;
                wait_d          = '0;
                state_d         = S_T1;
            end
            S_T1: begin
                ctrl_d.zlo_out = 1'b1;
                ctrl_d.read    = 1'b1;
                ctrl_d.mdr_in  = 1'b1;
                ctrl_d.busy    = 1'b1;
                if (wait_q == '0) begin
                    ctrl_d.pc_in  = 1'b1;
                    ctrl_d.inc_pc = 1'b1;
                end
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = S_T2;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_T2: begin
                ctrl_d.mdr_out = 1'b1;
                ctrl_d.ir_in   = 1'b1;
                ctrl_d.busy    = 1'b1;
                state_d        = S_T3;
            end
            S_T3: begin
                if (trap_c) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    ctrl_d.rout = sel_onehot(rb);
                    ctrl_d.y_in = 1'b1;
                    ctrl_d.busy = 1'b1;
                    state_d     = S_T4;
                end
            end
            S_T4: begin
                ctrl_d.rout     = sel_onehot(rc);
                ctrl_d.z_in     = 1'b1;
                ctrl_d.alu_ctrl = opcode;
                ctrl_d.busy     = 1'b1;
                state_d         = S_T5;
            end
            S_T5: begin
                ctrl_d.zlo_out = 1'b1;
                ctrl_d.busy    = 1'b1;
                if ((opcode == OP_MUL) || (opcode == OP_DIV)) begin
                    ctrl_d.lo_in = 1'b1;
                    state_d      = S_T6;
                end else begin
                    ctrl_d.rin  = sel_onehot(ra);
                    ctrl_d.done = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_T6: begin
                ctrl_d.zhi_out = 1'b1;
                ctrl_d.hi_in   = 1'b1;
                ctrl_d.done    = 1'b1;
                ctrl_d.busy    = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, wait counter, error flag and registered controls.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            ctrl_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ctrl_q  <= ctrl_d;
            error_q <= error_d;
        end
    end

    assign bus.Rin         = ctrl_q.rin;
    assign bus.Rout        = ctrl_q.rout;
    assign bus.PCout       = ctrl_q.pc_out;
    assign bus.ZLOout      = ctrl_q.zlo_out;
    assign bus.ZHIout      = ctrl_q.zhi_out;
    assign bus.MDRout      = ctrl_q.mdr_out;
    assign bus.MARin       = ctrl_q.mar_in;
    assign bus.Zin         = ctrl_q.z_in;
    assign bus.PCin        = ctrl_q.pc_in;
    assign bus.MDRin       = ctrl_q.mdr_in;
    assign bus.IRin        = ctrl_q.ir_in;
    assign bus.Yin         = ctrl_q.y_in;
    assign bus.LOin        = ctrl_q.lo_in;
    assign bus.HIin        = ctrl_q.hi_in;
    assign bus.IncrementPC = ctrl_q.inc_pc;
    assign bus.Read        = ctrl_q.read;
    assign bus.ALUControl  = ctrl_q.alu_ctrl;
    assign bus.Busy        = ctrl_q.busy;
    assign bus.Done        = ctrl_q.done;
    assign bus.Error       = error_q;
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb_alu_instr_sequencer: directed bench for alu_instr_sequencer with two
// instances (16 regs / MEM_WAIT=1 and 8 regs / MEM_WAIT=3) on one clock.
module tb_alu_instr_sequencer;
    logic Clock = 1'b0;
    logic Reset_n;
    int   tests = 0;
    int   fails = 0;

    always #5 Clock = ~Clock;

    alu_seq_if #(.NUM_REGS(16)) b1 ();
    alu_seq_if #(.NUM_REGS(8))  b3 ();

    alu_instr_sequencer #(.NUM_REGS(16), .SEL_W(4), .MEM_WAIT(1)) u1 (
        .Clock(Clock), .Reset_n(Reset_n), .bus(b1)
    );
    alu_instr_sequencer #(.NUM_REGS(8), .SEL_W(4), .MEM_WAIT(3)) u3 (
        .Clock(Clock), .Reset_n(Reset_n), .bus(b3)
    );

    // Single-bit controls packed MSB->LSB in the order of the F_* masks.
    logic [16:0] f1, f3;
    assign f1 = {b1.PCout, b1.ZLOout, b1.ZHIout, b1.MDRout, b1.MARin, b1.Zin,
                 b1.PCin, b1.MDRin, b1.IRin, b1.Yin, b1.LOin, b1.HIin,
                 b1.IncrementPC, b1.Read, b1.Busy, b1.Done, b1.Error};
    assign f3 = {b3.PCout, b3.ZLOout, b3.ZHIout, b3.MDRout, b3.MARin, b3.Zin,
                 b3.PCin, b3.MDRin, b3.IRin, b3.Yin, b3.LOin, b3.HIin,
                 b3.IncrementPC, b3.Read, b3.Busy, b3.Done, b3.Error};

    localparam logic [16:0] F_PCOUT  = 17'h10000;
    localparam logic [16:0] F_ZLOOUT = 17'h08000;
    localparam logic [16:0] F_MDROUT = 17'h02000;
    localparam logic [16:0] F_MARIN  = 17'h01000;
    localparam logic [16:0] F_ZIN    = 17'h00800;
    localparam logic [16:0] F_PCIN   = 17'h00400;
    localparam logic [16:0] F_MDRIN  = 17'h00200;
    localparam logic [16:0] F_IRIN   = 17'h00100;
    localparam logic [16:0] F_YIN    = 17'h00080;
    localparam logic [16:0] F_INC    = 17'h00010;
    localparam logic [16:0] F_READ   = 17'h00008;
    localparam logic [16:0] F_BUSY   = 17'h00004;
    localparam logic [16:0] F_DONE   = 17'h00002;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    int          read_cnt, pcin_cnt, done_cnt, done_at, rin_cnt, lo_at, hi_at;
    int          pc_first, pc_second, err_at, busy_cnt;
    logic [31:0] y_rout, alu_t4;

    initial begin
        Reset_n    = 1'b0;
        b1.Start   = 1'b0;
        b3.Start   = 1'b0;
        b1.IR_data = 32'h0;
        b3.IR_data = 32'h0;

        // Reset held two cycles
        step();
        step();
        chk("rst_flags1", 32'(f1), 32'h0);
        chk("rst_rin1", 32'(b1.Rin), 32'h0);
        chk("rst_rout1", 32'(b1.Rout), 32'h0);
        chk("rst_alu1", 32'(b1.ALUControl), 32'h0);
        chk("rst_flags3", 32'(f3), 32'h0);
        Reset_n = 1'b1;

        // R1 <- R2 op00101 R3, MEM_WAIT=1, step by step
        b1.IR_data = 32'h28918000;
        b1.Start   = 1'b1;
        step();
        b1.Start = 1'b0;
        chk("accept_idle", 32'(f1), 32'h0);
        step();
        chk("t0_flags", 32'(f1), 32'(F_PCOUT | F_MARIN | F_ZIN | F_BUSY));
        chk("t0_alu", 32'(b1.ALUControl), 32'h0);
        step();
        chk("t1_flags", 32'(f1), 32'(F_ZLOOUT | F_READ | F_MDRIN | F_PCIN | F_INC | F_BUSY));
        step();
        chk("t2_flags", 32'(f1), 32'(F_MDROUT | F_IRIN | F_BUSY));
        b1.Start = 1'b1;
        step();
        b1.Start = 1'b0;
        chk("t3_flags", 32'(f1), 32'(F_YIN | F_BUSY));
        chk("t3_rout", 32'(b1.Rout), 32'h0004);
        step();
        chk("t4_flags", 32'(f1), 32'(F_ZIN | F_BUSY));
        chk("t4_rout", 32'(b1.Rout), 32'h0008);
        chk("t4_alu", 32'(b1.ALUControl), 32'h05);
        step();
        chk("t5_flags", 32'(f1), 32'(F_ZLOOUT | F_DONE | F_BUSY));
        chk("t5_rin", 32'(b1.Rin), 32'h0002);
        chk("t5_rout", 32'(b1.Rout), 32'h0);
        step();
        chk("post_idle_a", 32'(f1), 32'h0);
        step();
        chk("post_idle_b", 32'(f1), 32'h0);

        // MEM_WAIT=3 fetch
        b3.IR_data = 32'h28918000;
        b3.Start   = 1'b1;
        read_cnt = 0; pcin_cnt = 0; done_cnt = 0; done_at = 0; y_rout = 32'hDEAD;
        for (int n = 1; n <= 14; n++) begin
            step();
            b3.Start = 1'b0;
            if (b3.Read) read_cnt++;
            if (b3.PCin) pcin_cnt++;
            if (b3.Yin) y_rout = 32'(b3.Rout);
            if (b3.Done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
        end
        chk("mw3_read_cycles", 32'(read_cnt), 32'd3);
        chk("mw3_pcin_cycles", 32'(pcin_cnt), 32'd1);
        chk("mw3_done_cycle", 32'(done_at), 32'd9);
        chk("mw3_done_count", 32'(done_cnt), 32'd1);
        chk("mw3_t3_rout", y_rout, 32'h04);

        // Rb=9 on an 8-register instance
        b3.IR_data = 32'h28C98000;
        b3.Start   = 1'b1;
        done_cnt = 0; done_at = 0; y_rout = 32'hDEAD;
        for (int n = 1; n <= 14; n++) begin
            step();
            b3.Start = 1'b0;
            if (b3.Yin) y_rout = 32'(b3.Rout);
            if (b3.Done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
        end
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        chk("oor_trap_done", 32'(done_cnt), 32'd0);
        chk("oor_trap_error", 32'(b3.Error), 32'd1);
`else
        chk("oor_rout_none", y_rout, 32'h0);
        chk("oor_done_cycle", 32'(done_at), 32'd9);
`endif

        // Mul with Start held high throughout
        b1.IR_data = 32'h78918000;
        b1.Start   = 1'b1;
        rin_cnt = 0; lo_at = 0; hi_at = 0; done_at = 0; done_cnt = 0;
        pc_first = 0; pc_second = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (b1.Rin != '0) rin_cnt++;
            if (b1.LOin && b1.ZLOout) lo_at = n;
            if (b1.HIin && b1.ZHIout) hi_at = n;
            if (b1.Done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
            if (b1.PCout) begin
                if (pc_first == 0) pc_first = n;
                else if (pc_second == 0) pc_second = n;
            end
        end
        b1.Start = 1'b0;
        chk("mul_lo_cycle", 32'(lo_at), 32'd7);
        chk("mul_hi_cycle", 32'(hi_at), 32'd8);
        chk("mul_done_cycle", 32'(done_at), 32'd8);
        chk("mul_done_count", 32'(done_cnt), 32'd1);
        chk("mul_rin_never", 32'(rin_cnt), 32'd0);
        chk("mul_first_t0", 32'(pc_first), 32'd2);
        chk("mul_restart_t0", 32'(pc_second), 32'd10);

        // Second mul reaches T4, then reset aborts it
        step();
        step();
        chk("abort_at_t4", 32'(f1), 32'(F_ZIN | F_BUSY));
        chk("abort_t4_alu", 32'(b1.ALUControl), 32'h0F);
        Reset_n = 1'b0;
        step();
        chk("abort_flags", 32'(f1), 32'h0);
        chk("abort_rout", 32'(b1.Rout), 32'h0);
        chk("abort_alu", 32'(b1.ALUControl), 32'h0);
        Reset_n = 1'b1;
        done_cnt = 0; busy_cnt = 0;
        for (int n = 1; n <= 6; n++) begin
            step();
            if (b1.Done) done_cnt++;
            if (b1.Busy) busy_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_no_busy", 32'(busy_cnt), 32'd0);

        // Opcode 11111
        b1.IR_data = 32'hF8918000;
        b1.Start   = 1'b1;
        done_cnt = 0; done_at = 0; err_at = 0; alu_t4 = 32'hDEAD;
        for (int n = 1; n <= 10; n++) begin
            step();
            b1.Start = 1'b0;
            if (b1.Done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
            if (b1.Error && err_at == 0) err_at = n;
            if (b1.Zin && !b1.PCout) alu_t4 = 32'(b1.ALUControl);
        end
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        chk("ill_err_cycle", 32'(err_at), 32'd5);
        chk("ill_no_done", 32'(done_cnt), 32'd0);
        chk("ill_err_held", 32'(b1.Error), 32'd1);
        chk("ill_idle", 32'(b1.Busy), 32'd0);
`else
        chk("ill_done_cycle", 32'(done_at), 32'd7);
        chk("ill_no_error", 32'(err_at), 32'd0);
        chk("ill_t4_alu", alu_t4, 32'h1F);
`endif
        b1.IR_data = 32'h28918000;
        b1.Start   = 1'b1;
        step();
        b1.Start = 1'b0;
        chk("err_clear_on_start", 32'(b1.Error), 32'd0);
        step();
        chk("restart_t0", 32'(f1), 32'(F_PCOUT | F_MARIN | F_ZIN | F_BUSY));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_instr_sequencer.md
# alu_instr_sequencer

Parametrised control-step sequencer that replaces hand-driven control in the datapath benches. On `Start` it fetches one instruction (PC→MAR, memory read into MDR, MDR→IR), decodes the register-register ALU format from IR, and drives the per-step register enables, bus-out selects and `ALUControl` for the execute/writeback steps. It sits between the datapath and the top level, generalising the fixed T0–T5 sequence to configurable register count, memory wait states and two-word (HI/LO) results.

## Interface
- `NUM_REGS`, 16: general registers, one-hot `Rin`/`Rout` width.
- `SEL_W`, 4: register-select field width in IR.
- `MEM_WAIT`, 1: cycles `Read`/`MDRin` stay asserted in T1 (≥1).
- `Clock`  in  1  rising-edge clock.
- `Reset_n`  in  1  synchronous, active-low reset.
- `Start`  in  1  begin one instruction; sampled only in IDLE.
- `IR_data`  in  32  IR register output.
- `Rin`, `Rout`  out  NUM_REGS  one-hot register load / bus drive.
- `PCout`, `ZLOout`, `ZHIout`, `MDRout`  out  1 each  bus drive selects.
- `MARin`, `Zin`, `PCin`, `MDRin`, `IRin`, `Yin`, `LOin`, `HIin`  out  1 each  register loads.
- `IncrementPC`, `Read`  out  1 each.
- `ALUControl`  out  5  ALU operation.
- `Busy`  out  1  high in every state except IDLE.
- `Done`  out  1  one-cycle pulse in final step.
- `Error`  out  1  illegal-instruction flag (see Configuration).

## Operation
- IR fields: opcode `[31:27]`, Ra `[26:23]`, Rb `[22:19]`, Rc `[18:15]` (SEL_W bits each, MSB-aligned at those positions).
- States: IDLE → T0 → T1 → T2 → T3 → T4 → T5 → (T6 for mul/div) → IDLE.
- T0: `PCout`, `MARin`, `Zin`, `ALUControl`=00000 (pass-through +inc path).
- T1: `ZLOout`, `Read`, `MDRin` for MEM_WAIT cycles; `PCin`, `IncrementPC` only in first T1 cycle.
- T2: `MDRout`, `IRin`.
- T3: `Rout[Rb]`, `Yin`.
- T4: `Rout[Rc]`, `Zin`, `ALUControl`=opcode.
- T5: normal ops: `ZLOout`, `Rin[Ra]`, `Done`. Mul (01111) / div (10000): `ZLOout`, `LOin`.
- T6 (mul/div only): `ZHIout`, `HIin`, `Done`.
- All control outputs are 0 in IDLE and in any signal not listed for a step; at most one bus-out select high per cycle.
- Register index ≥ NUM_REGS: no `Rin`/`Rout` bit asserted for that field.
- `Start` while `Busy` ignored; `Start` held high in IDLE after `Done` starts a new instruction next cycle.

## Timing
- All outputs registered; state advances on rising `Clock`.
- `Start` high in IDLE at edge k → T0 outputs valid after edge k+1.
- Latency Start→Done: 6+MEM_WAIT cycles (normal), 7+MEM_WAIT (mul/div).
- Decode (T3 onward) uses `IR_data` sampled after T2's `IRin` edge.
- `Reset_n` low at any edge: state→IDLE, all outputs 0, `Error` cleared, wait counter cleared; abort mid-instruction, no `Done`.

## Configuration
- `ALU_SEQ_ILLEGAL_TRAP_EN` defined: opcode not in the ALU set (00000–10000 excluding 00000 fetch-pass code? no: legal set is 00011–10000) or any register index ≥ NUM_REGS → after T2 go to IDLE, `Error` high until next `Start` accepted, no `Done`.
- Undefined: illegal opcodes execute T3–T5 with `ALUControl`=opcode; `Error` tied 0.

## Test plan
- Reset: `Reset_n`=0 two cycles → all outputs 0, `Busy`=0.
- `IR_data`=0x28918000 (op 00101, R1←R2,R3), MEM_WAIT=1 → T3 `Rout`=0x0004, T4 `Rout`=0x0008, `ALUControl`=00101, T5 `Rin`=0x0002, `Done` 7 cycles after Start.
- MEM_WAIT=3 → `Read` high exactly 3 cycles, `PCin` exactly 1; Done at cycle 9.
- Mul opcode 01111 → T5 `LOin`, T6 `ZHIout`+`HIin`+`Done`; `Rin` never asserted.
- `Reset_n` low during T4 → next cycle IDLE, outputs 0, no `Done`; `Start` pulses during T1–T5 ignored.
- With trap macro, opcode 11111 → `Error`=1 after T2, no `Done`; without macro, `Done` at T5.
